nt_level_integrator: RTL and testbench
======================================

# nt_level_integrator

Sequential integrator that turns the per-neurotransmitter `inc`/`dec`/`fast` requests from a regulator stage into a stored concentration level. One instance per neurotransmitter sits directly downstream of its regulator. It periodically applies saturating slow or fast steps to an internal level and publishes a hysteretic 2-bit quantized level. That 2-bit value is the per-transmitter field the regulators consume inside `neurotransmitter_level`.

## Interface
Parameters:
- `WIDTH`, 8: internal level width, minimum 4.
- `TICK_DIV`, 16: clock cycles per update tick, minimum 1.
- `SLOW_STEP`, 1: step applied when `fast` = 0.
- `FAST_STEP`, 4: step applied when `fast` = 1.
- `HYST`, 8: quantizer hysteresis margin in level LSBs.
- `RESET_LEVEL`, 128: level loaded at reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: when low, the prescaler and level are frozen.
- `inc` input 1: raise request from the regulator.
- `dec` input 1: lower request from the regulator.
- `fast` input 1: selects `FAST_STEP` instead of `SLOW_STEP`.
- `level` output `WIDTH`: current internal level, registered.
- `level_q` output 2: quantized level, registered. 00 = low, 11 = high.
- `sat_hi` output 1: high while `level` = 2^WIDTH−1.
- `sat_lo` output 1: high while `level` = 0.
- `q_changed` output 1: one-cycle pulse when `level_q` changes.

## Operation
- Prescaler:
  - Counter `div` runs 0..TICK_DIV−1 and advances only when `ena` = 1.
  - `tick` = `ena` && (`div` == TICK_DIV−1). On a tick, `div` wraps to 0.
  - When TICK_DIV = 1, `tick` = `ena` on every cycle.
- Level update, on `tick` only. Step = `fast` ? FAST_STEP : SLOW_STEP.
  - `inc` && !`dec`: level = min(level + step, 2^WIDTH−1). Compute in WIDTH+1 bits; saturate, never wrap.
  - `dec` && !`inc`: level = max(level − step, 0). Saturate, never wrap.
  - `inc` && `dec`, or neither: idle request, handled per Configuration. `fast` is ignored.
- Quantizer, a 4-state FSM Q0..Q3 held in `level_q`. Thresholds are T1 = 1<<(WIDTH−2), T2 = 2·T1, T3 = 3·T1.
  - Evaluated on every cycle, independent of `ena`.
  - Moves at most one state per cycle.
  - Up from Qk (k<3) when `level` ≥ T(k+1) + HYST.
  - Down from Qk (k>0) when `level` < Tk − HYST.
  - Otherwise the state holds. Up and down are mutually exclusive because the bands do not overlap.
- `q_changed` is registered: 1 on the cycle after any `level_q` transition, 0 otherwise.
- `sat_hi` and `sat_lo` are decoded combinationally from the registered `level`.

## Timing
- Reset values (asynchronous assert; release is synchronous to `clk` per system reset sync):
  - `div` = 0, `level` = RESET_LEVEL, `q_changed` = 0.
  - `level_q` = RESET_LEVEL[WIDTH−1:WIDTH−2], which is Q2 for the defaults.
  - `sat_hi` and `sat_lo` follow from `level`.
- Inputs `inc`, `dec`, `fast` are sampled only on the tick cycle. `level` updates on that same clock edge.
- `level_q` reacts one cycle after `level` crosses a band.
  - If a single step crosses two bands, `level_q` takes consecutive cycles, one state per cycle.
- `q_changed` asserts one cycle after `level_q` updates, i.e. 2 cycles after the `level` edge for a single-state move.
- Reset asserted mid-operation: all state returns to reset values immediately. Any pending tick is discarded.
- `ena` falling edge: `div` holds its value, and the count resumes from there when `ena` rises.

## Configuration
- `NT_HOMEOSTASIS_EN` defined:
  - On a tick with an idle request, `level` moves 1 LSB toward the midpoint 2^(WIDTH−1).
  - At the midpoint, `level` holds.
- Not defined:
  - On an idle request, `level` holds.
  - The midpoint-compare logic is removed entirely.

## Test plan
All scenarios use default parameters.
- Reset check: assert `rst_n` = 0 mid-run -> immediately `level` = 128, `level_q` = 2, `sat_hi` = `sat_lo` = 0, `q_changed` = 0.
- Slow rise: `ena` = 1, `inc` = 1 held.
  - After 16 cycles, `level` = 129.
  - `level` reaches 200 after 72 ticks; one cycle later `level_q` = 3; the cycle after that, `q_changed` pulses once.
- Fast fall and saturation: from 6, hold `dec` = `fast` = 1.
  - Over successive ticks, `level` = 2, then 0.
  - `sat_lo` = 1 and `level` stays 0 on further ticks, with no wrap to 255.
- Hysteresis: at `level` = 200 with `level_q` = 3, step down slowly.
  - `level_q` stays 3 down through `level` = 184.
  - `level_q` becomes 2 one cycle after `level` = 183.
- Conflict and idle: `inc` = `dec` = 1 with `fast` = 1 at `level` = 131 for 3 ticks.
  - Without the macro: `level` stays 131.
  - With `NT_HOMEOSTASIS_EN`: `level` = 130, 129, 128, then holds at 128.
- Enable freeze: drop `ena` at `div` = 10 for 50 cycles with `inc` = 1.
  - `level` is unchanged while `ena` is low.
  - After `ena` rises, the next update occurs exactly 6 cycles later.

Source files
------------

// File: rtl/nt_level_integrator.sv
// nt_level_integrator
// Per-neurotransmitter concentration integrator. A prescaler produces an
// update tick every TICK_DIV enabled cycles; on each tick the stored level
// takes a saturating slow or fast step according to the regulator's
// inc/dec/fast requests. A 4-state hysteretic quantizer publishes the 2-bit
// level consumed by the regulators.
// Optional feature macro: NT_HOMEOSTASIS_EN (idle ticks drift level by one
// LSB toward the midpoint 2^(WIDTH-1)).
module nt_level_integrator #(
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 16,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 4,
    parameter int HYST        = 8,
    parameter int RESET_LEVEL = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       level_q,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             q_changed
);

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] LVL_MAX  = '1;
    localparam logic [WIDTH-1:0] RESET_LV = WIDTH'(RESET_LEVEL);
    localparam logic [WIDTH:0]   SLOW_W   = (WIDTH + 1)'(SLOW_STEP);
    localparam logic [WIDTH:0]   FAST_W   = (WIDTH + 1)'(FAST_STEP);

    // Quantizer thresholds, kept in 32 bits so T+HYST never overflows
    localparam logic [31:0] T1     = 32'(1) << (WIDTH - 2);
    localparam logic [31:0] T2     = 32'(2) * T1;
    localparam logic [31:0] T3     = 32'(3) * T1;
    localparam logic [31:0] HYST32 = 32'(HYST);

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } q_state_t;

    localparam q_state_t Q_RESET = q_state_t'(RESET_LV[WIDTH-1:WIDTH-2]);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] level_next;
    logic [31:0]      lvl_ext;
    q_state_t         q_state;
    logic             q_moved;

    assign tick    = ena && (div == DIV_LAST);
    assign lvl_ext = 32'(level);
    assign level_q = q_state;
    assign sat_hi  = (level == LVL_MAX);
    assign sat_lo  = (level == '0);

    // Next level: saturating step on a tick, idle handling otherwise
    always_comb begin
        step       = fast ? FAST_W : SLOW_W;
        sum        = {1'b0, level} + step;
        level_next = level;
        if (tick) begin
            if (inc && !dec) begin
                level_next = (sum > {1'b0, LVL_MAX}) ? LVL_MAX : sum[WIDTH-1:0];
            end else if (dec && !inc) begin
                level_next = ({1'b0, level} < step) ? '0 : (level - step[WIDTH-1:0]);
            end else begin
`ifdef NT_HOMEOSTASIS_EN
                if (level < (WIDTH'(1) << (WIDTH - 1))) begin
                    level_next = level + WIDTH'(1);
                end else if (level > (WIDTH'(1) << (WIDTH - 1))) begin
                    level_next = level - WIDTH'(1);
                end
`else
                level_next = level;
`endif
            end
        end
    end

    // Prescaler counter and level register; both freeze while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            level <= RESET_LV;
        end else begin
            if (ena) begin
                div <= tick ? '0 : (div + DIV_W'(1));
            end
            level <= level_next;
        end
    end

    // Hysteretic quantizer FSM, one state per cycle, plus delayed change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_state   <= Q_RESET;
            q_moved   <= 1'b0;
            q_changed <= 1'b0;
        end else begin
            q_moved   <= 1'b0;
            q_changed <= q_moved;
            case (q_state)
                Q0: begin
                    if (lvl_ext >= T1 + HYST32) begin
                        q_state <= Q1;
                        q_moved <= 1'b1;
                    end
                end
                Q1: begin
                    if (lvl_ext >= T2 + HYST32) begin
                        q_state <= Q2;
                        q_moved <= 1'b1;
                    end else if (lvl_ext + HYST32 < T1) begin
                        q_state <= Q0;
                        q_moved <= 1'b1;
                    end
                end
                Q2: begin
                    if (lvl_ext >= T3 + HYST32) begin
                        q_state <= Q3;
                        q_moved <= 1'b1;
                    end else if (lvl_ext + HYST32 < T2) begin
                        q_state <= Q1;
                        q_moved <= 1'b1;
                    end
                end
                default: begin
                    if (lvl_ext + HYST32 < T3) begin
                        q_state <= Q2;
                        q_moved <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nt_level_integrator.sv
// tb_nt_level_integrator
// Randomized and directed stimulus against an integer-arithmetic reference
// model of the integrator (defaults: WIDTH=8, TICK_DIV=16, steps 1/4,
// HYST=8, RESET_LEVEL=128). Honours NT_HOMEOSTASIS_EN when defined.
module tb_nt_level_integrator;

    localparam int TICK_DIV = 16;
    localparam int MAXLV    = 255;
    localparam int MID      = 128;
    localparam int HYST     = 8;

    logic       clk;
    logic       rst_n;
    logic       ena, inc, dec, fast;
    logic [7:0] level;
    logic [1:0] level_q;
    logic       sat_hi, sat_lo, q_changed;

    int tests;
    int fails;

    // reference model state
    int m_div, m_level, m_q, m_q_prev, m_qchg;
    int thr [4];

    nt_level_integrator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .inc       (inc),
        .dec       (dec),
        .fast      (fast),
        .level     (level),
        .level_q   (level_q),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo),
        .q_changed (q_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div    = 0;
        m_level  = 128;
        m_q      = 2;
        m_q_prev = 2;
        m_qchg   = 0;
    endtask

    task automatic compare_all();
        check("level", int'(level), m_level);
        check("level_q", int'(level_q), m_q);
        check("sat_hi", int'(sat_hi), (m_level == MAXLV) ? 1 : 0);
        check("sat_lo", int'(sat_lo), (m_level == 0) ? 1 : 0);
        check("q_changed", int'(q_changed), m_qchg);
    endtask

    // One clock cycle: apply inputs, advance the model by the spec rules, compare
    task automatic step(input bit e, input bit i, input bit d, input bit f);
        bit tk;
        int st, nl, nq;
        ena = e; inc = i; dec = d; fast = f;
        @(posedge clk);
        tk = e && (m_div == TICK_DIV - 1);
        st = f ? 4 : 1;
        nl = m_level;
        if (tk) begin
            if (i && !d)      nl = (m_level + st > MAXLV) ? MAXLV : m_level + st;
            else if (d && !i) nl = (m_level - st < 0) ? 0 : m_level - st;
            else begin
`ifdef NT_HOMEOSTASIS_EN
                if (m_level < MID)      nl = m_level + 1;
                else if (m_level > MID) nl = m_level - 1;
`endif
            end
        end
        nq = m_q;
        if (m_q < 3 && m_level >= thr[m_q + 1] + HYST)  nq = m_q + 1;
        else if (m_q > 0 && m_level < thr[m_q] - HYST) nq = m_q - 1;
        m_qchg   = (m_q != m_q_prev) ? 1 : 0;
        m_q_prev = m_q;
        m_q      = nq;
        m_level  = nl;
        if (e) m_div = tk ? 0 : m_div + 1;
        #1;
        compare_all();
    endtask

    initial begin
        int lv0;
        int n;
        tests = 0;
        fails = 0;
        for (int k = 0; k < 4; k++) thr[k] = k * 64;
        ena = 0; inc = 0; dec = 0; fast = 0;
        rst_n = 0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1;
        compare_all();

        // short random run, then asynchronous reset mid-operation
        for (int k = 0; k < 100; k++)
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        model_reset();
        check("rst_level", int'(level), 128);
        check("rst_level_q", int'(level_q), 2);
        check("rst_sat_hi", int'(sat_hi), 0);
        check("rst_sat_lo", int'(sat_lo), 0);
        check("rst_q_changed", int'(q_changed), 0);
        @(negedge clk);
        rst_n = 1;

        // slow rise
        for (int k = 0; k < 16; k++) step(1, 1, 0, 0);
        check("rise_16", int'(level), 129);
        for (int k = 16; k < 72 * 16; k++) step(1, 1, 0, 0);
        check("rise_200", int'(level), 200);
        check("rise_q_still2", int'(level_q), 2);
        step(1, 1, 0, 0);
        check("rise_q3", int'(level_q), 3);
        step(1, 1, 0, 0);
        check("rise_qchg", int'(q_changed), 1);
        step(1, 1, 0, 0);
        check("rise_qchg_end", int'(q_changed), 0);

        // hysteresis on slow descent
        n = 0;
        while (m_level != 183 && n < 2000) begin
            step(1, 0, 1, 0);
            n++;
        end
        check("hyst_reach_timeout", (n < 2000) ? 1 : 0, 1);
        check("hyst_level183", int'(level), 183);
        check("hyst_q_hold3", int'(level_q), 3);
        step(1, 0, 1, 0);
        check("hyst_q2", int'(level_q), 2);

        // fast fall into low saturation via 6
        n = 0;
        while (m_level != 7 && n < 4000) begin
            step(1, 0, 1, 1);
            n++;
        end
        n = 0;
        while (m_level != 6 && n < 40) begin
            step(1, 0, 1, 0);
            n++;
        end
        check("fall_level6", int'(level), 6);
        for (int k = 0; k < 16; k++) step(1, 0, 1, 1);
        check("fall_level2", int'(level), 2);
        for (int k = 0; k < 16; k++) step(1, 0, 1, 1);
        check("fall_level0", int'(level), 0);
        for (int k = 0; k < 48; k++) step(1, 0, 1, 1);
        check("fall_hold0", int'(level), 0);
        check("fall_sat_lo", int'(sat_lo), 1);

        // conflict / idle at 131
        n = 0;
        while (m_level != 128 && n < 1000) begin
            step(1, 1, 0, 1);
            n++;
        end
        n = 0;
        while (m_level != 131 && n < 100) begin
            step(1, 1, 0, 0);
            n++;
        end
        check("idle_start131", int'(level), 131);
        for (int t = 1; t <= 4; t++) begin
            for (int k = 0; k < 16; k++) step(1, 1, 1, 1);
`ifdef NT_HOMEOSTASIS_EN
            check("idle_homeo", int'(level), (t < 3) ? 131 - t : 128);
`else
            check("idle_hold", int'(level), 131);
`endif
        end

        // enable freeze at div == 10
        n = 0;
        while (m_div != 10 && n < 40) begin
            step(1, 1, 0, 0);
            n++;
        end
        lv0 = m_level;
        for (int k = 0; k < 50; k++) step(0, 1, 0, 0);
        check("freeze_hold", int'(level), lv0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
        check("freeze_no_early", int'(level), lv0);
        step(1, 1, 0, 0);
        check("freeze_resume6", int'(level), lv0 + 1);

        // high saturation
        n = 0;
        while (m_level != MAXLV && n < 2000) begin
            step(1, 1, 0, 1);
            n++;
        end
        check("sat_reach_timeout", (n < 2000) ? 1 : 0, 1);
        check("sat_hi_flag", int'(sat_hi), 1);
        for (int k = 0; k < 32; k++) step(1, 1, 0, 1);
        check("sat_hold255", int'(level), MAXLV);

        // randomized traffic
        for (int k = 0; k < 4000; k++)
            step(($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
